// File: rtl/phase_meas_sched.sv
// Round-robins the shared one-shot phase core over channels 1..NUM_CH-1 and averages 2^avg_log2 samples per result.
// Latency: final core_done -> res_valid two cycles later; no backpressure, results are one-cycle strobes.
module phase_meas_sched #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int RST_CYC     = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [NUM_CH-2:0] ch_mask,
   input  logic [1:0]        avg_log2,
   output logic              core_rst_n,
   output logic [CH_W-1:0]   sel_b,
   input  logic              core_done,
   input  logic [8:0]        core_phase,
   output logic              res_valid,
   output logic [CH_W-1:0]   res_ch,
   output logic [8:0]        res_phase,
   output logic              res_timeout,
   output logic              busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_RESET  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_ACCUM  = 3'd4;
   localparam logic [2:0] S_REPORT = 3'd5;

   localparam int                 RC_W    = $clog2(RST_CYC + 1);
   localparam logic [RC_W-1:0]    RC_LAST = RC_W'(RST_CYC - 1);
   localparam logic [23:0]        TO_LAST = 24'(TIMEOUT_CYC - 1);
   localparam logic signed [12:0] DEG180  = 13'sd180;
   localparam logic signed [12:0] DEG360  = 13'sd360;

   logic [2:0]         state_q, state_d;
   logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
   logic [CH_W-1:0]    sel_b_q, sel_b_d;
   logic [CH_W-1:0]    res_ch_q, res_ch_d;
   logic [1:0]         n_log2_q, n_log2_d;
   logic [3:0]         cnt_q, cnt_d;
   logic signed [12:0] acc_q, acc_d;
   logic [8:0]         ref_q, ref_d;
   logic [8:0]         samp_q, samp_d;
   logic [8:0]         res_phase_q, res_phase_d;
   logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
   logic [23:0]        to_cnt_q, to_cnt_d;
   logic               core_rst_n_q, core_rst_n_d;
   logic               res_valid_q, res_valid_d;
   logic               res_timeout_q, res_timeout_d;

   logic [CH_W:0]      nxt;
   logic signed [12:0] s_v, r_v, diff_v, add_v, avg_v;
   logic [3:0]         target_v;
   logic               rep_go, rep_to;
   logic [8:0]         rep_phase;

   // {found, channel}: first enabled channel after cur, wrapping NUM_CH-1 -> 1; channel 0 is never a candidate
   function automatic logic [CH_W:0] next_ch(input logic [CH_W-1:0] cur, input logic [NUM_CH-2:0] mask);
      logic [CH_W:0] r;
      int            idx;
      r = '0;
      for (int k = NUM_CH - 1; k >= 1; k--) begin
         idx = ((int'(cur) - 1 + k) % (NUM_CH - 1)) + 1;
         if (mask[idx-1]) r = {1'b1, CH_W'(idx)};
      end
      return r;
   endfunction

   assign nxt = next_ch(cur_ch_q, ch_mask);

   always_comb begin
      state_d       = state_q;
      cur_ch_d      = cur_ch_q;
      sel_b_d       = sel_b_q;
      res_ch_d      = res_ch_q;
      n_log2_d      = n_log2_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      ref_d         = ref_q;
      samp_d        = samp_q;
      res_phase_d   = res_phase_q;
      rst_cnt_d     = rst_cnt_q;
      to_cnt_d      = to_cnt_q;
      res_timeout_d = res_timeout_q;
      res_valid_d   = 1'b0;
      rep_go        = 1'b0;
      rep_to        = 1'b0;
      rep_phase     = '0;
      avg_v         = '0;

      // Unwrap the new sample against the first one so a cluster straddling 0/360 averages correctly
      s_v    = $signed({4'b0000, samp_q});
      r_v    = (cnt_q == 4'd0) ? s_v : $signed({4'b0000, ref_q});
      diff_v = s_v - r_v;
      if (diff_v > DEG180)       add_v = s_v - DEG360;
      else if (diff_v < -DEG180) add_v = s_v + DEG360;
      else                       add_v = s_v;
      target_v = 4'd1 << n_log2_q;

      case (state_q)
         S_IDLE: begin
            if (|ch_mask) state_d = S_SELECT;
         end
         S_SELECT: begin
            if (nxt[CH_W]) begin
               cur_ch_d  = nxt[CH_W-1:0];
               sel_b_d   = nxt[CH_W-1:0];
               n_log2_d  = avg_log2;
               cnt_d     = '0;
               acc_d     = '0;
               rst_cnt_d = '0;
               state_d   = S_RESET;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RESET: begin
            if (rst_cnt_q == RC_LAST) begin
               to_cnt_d = '0;
               state_d  = S_WAIT;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         S_WAIT: begin
            to_cnt_d = to_cnt_q + 24'd1;
            if (core_done) begin
               samp_d  = core_phase;
               state_d = S_ACCUM;
            end else if (to_cnt_q == TO_LAST) begin
               rep_go  = 1'b1;
               rep_to  = 1'b1;
               state_d = S_REPORT;
            end
         end
         S_ACCUM: begin
            acc_d = acc_q + add_v;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd0) ref_d = samp_q;
            if (cnt_d == target_v) begin
               avg_v = acc_d >>> n_log2_q;
               if (avg_v < 13'sd0)        avg_v = avg_v + DEG360;
               else if (avg_v >= DEG360)  avg_v = avg_v - DEG360;
               rep_go    = 1'b1;
               rep_phase = 9'(avg_v);
               state_d   = S_REPORT;
            end else begin
               rst_cnt_d = '0;
               state_d   = S_RESET;
            end
         end
         S_REPORT: begin
            state_d = (|ch_mask) ? S_SELECT : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Dropping enable abandons the channel: no result, partial samples are never reported
      if (!enable) begin
         state_d = S_IDLE;
      end else if (rep_go) begin
         res_valid_d   = 1'b1;
         res_ch_d      = cur_ch_q;
         res_phase_d   = rep_phase;
         res_timeout_d = rep_to;
      end

      core_rst_n_d = !(state_d == S_IDLE || state_d == S_RESET);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cur_ch_q      <= CH_W'(NUM_CH - 1);
         sel_b_q       <= CH_W'(1);
         res_ch_q      <= '0;
         n_log2_q      <= '0;
         cnt_q         <= '0;
         acc_q         <= '0;
         ref_q         <= '0;
         samp_q        <= '0;
         res_phase_q   <= '0;
         rst_cnt_q     <= '0;
         to_cnt_q      <= '0;
         core_rst_n_q  <= 1'b0;
         res_valid_q   <= 1'b0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_ch_q      <= cur_ch_d;
         sel_b_q       <= sel_b_d;
         res_ch_q      <= res_ch_d;
         n_log2_q      <= n_log2_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         ref_q         <= ref_d;
         samp_q        <= samp_d;
         res_phase_q   <= res_phase_d;
         rst_cnt_q     <= rst_cnt_d;
         to_cnt_q      <= to_cnt_d;
         core_rst_n_q  <= core_rst_n_d;
         res_valid_q   <= res_valid_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   assign core_rst_n  = core_rst_n_q;
   assign sel_b       = sel_b_q;
   assign res_valid   = res_valid_q;
   assign res_ch      = res_ch_q;
   assign res_phase   = res_phase_q;
   assign res_timeout = res_timeout_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_phase_meas_sched.sv
// Bench for phase_meas_sched: a scripted core responder issues samples, a monitor scores results.
`timescale 1ns/1ps
module tb_phase_meas_sched;

   localparam int NUM_CH  = 4;
   localparam int CH_W    = 2;
   localparam int RST_CYC = 16;
   localparam int TO_CYC  = 300;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic [NUM_CH-2:0] ch_mask;
   logic [1:0]        avg_log2;
   logic              core_rst_n;
   logic [CH_W-1:0]   sel_b;
   logic              core_done;
   logic [8:0]        core_phase;
   logic              res_valid;
   logic [CH_W-1:0]   res_ch;
   logic [8:0]        res_phase;
   logic              res_timeout;
   logic              busy;

   typedef struct {
      int ch;
      int ph;
      int to;
      int cyc;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              mon_e;
   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   int                m_cur;
   int                sbuf[8];
   bit                mid_en = 1'b0;
   logic [NUM_CH-2:0] mid_mask = '0;
   int                w0;

   phase_meas_sched #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .RST_CYC(RST_CYC), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .avg_log2(avg_log2),
      .core_rst_n(core_rst_n), .sel_b(sel_b), .core_done(core_done), .core_phase(core_phase),
      .res_valid(res_valid), .res_ch(res_ch), .res_phase(res_phase),
      .res_timeout(res_timeout), .busy(busy)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   // Reference channel order: next enabled channel above the current one, else the lowest enabled one
   function automatic int model_next(input logic [NUM_CH-2:0] mask);
      for (int c = m_cur + 1; c < NUM_CH; c++) if (mask[c-1]) return c;
      for (int c = 1; c <= m_cur; c++) if (mask[c-1]) return c;
      return m_cur;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got res_valid ch %0d phase %0d, required none", res_ch, res_phase);
         end else begin
            mon_e = exp_q.pop_front();
            chk("res_ch", int'(res_ch), mon_e.ch);
            chk("res_phase", int'(res_phase), mon_e.ph);
            chk("res_timeout", int'(res_timeout), mon_e.to);
            chk("res_cycle", cyc, mon_e.cyc);
         end
      end
   end

   // Waits for the next core restart pulse, checks its width, returns the first WAIT cycle.
   // A stray core_done is pulsed while the core is held in reset; it must be ignored.
   task automatic await_wait(output int w);
      int g;
      int lo;
      g  = 0;
      lo = 0;
      while (!core_rst_n && g < 2000) begin @(negedge clk); g++; end
      while (core_rst_n && g < 2000) begin @(negedge clk); g++; end
      while (!core_rst_n && g < 2000) begin
         lo++;
         core_done  = (lo == 3);
         core_phase = 9'd123;
         @(negedge clk);
         g++;
      end
      core_done = 1'b0;
      if (g >= 2000) fail_bound("await_wait");
      else chk("rst_low_cycles", lo, RST_CYC);
      w = cyc;
   endtask

   task automatic run_job(input int nl, input bit use_buf, input int dly);
      int n, ch, sum, r, v, avg, w, d, ctr;
      n   = 1 << nl;
      ch  = model_next(ch_mask);
      m_cur = ch;
      ctr = int'($urandom_range(0, 359));
      if (!use_buf)
         for (int i = 0; i < n; i++) sbuf[i] = (ctr + int'($urandom_range(0, 120)) + 300) % 360;
      r   = sbuf[0];
      sum = 0;
      for (int i = 0; i < n; i++) begin
         v = sbuf[i];
         if (v - r > 180) v = v - 360;
         else if (r - v > 180) v = v + 360;
         sum += v;
      end
      avg = sum / n;
      if ((sum % n) != 0 && sum < 0) avg--;
      if (avg < 0) avg += 360;
      else if (avg >= 360) avg -= 360;
      for (int i = 0; i < n; i++) begin
         await_wait(w);
         chk("sel_b", int'(sel_b), ch);
         if (i == 0 && mid_en) ch_mask = mid_mask;
         d = (dly < 0) ? int'($urandom_range(0, 40)) : dly;
         repeat (d) @(negedge clk);
         if (i == n - 1) exp_q.push_back('{ch, avg, 0, cyc + 2});
         core_phase = 9'(sbuf[i]);
         core_done  = 1'b1;
         @(negedge clk);
         core_done  = 1'b0;
         core_phase = 9'($urandom_range(0, 359));
      end
   endtask

   task automatic run_timeout();
      int ch, w;
      ch = model_next(ch_mask);
      m_cur = ch;
      await_wait(w);
      chk("sel_b_timeout", int'(sel_b), ch);
      exp_q.push_back('{ch, 0, 1, w + TO_CYC});
      repeat (TO_CYC) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_core_rst_n"}, int'(core_rst_n), 0);
      chk({tag, "_sel_b"}, int'(sel_b), 1);
      chk({tag, "_res_valid"}, int'(res_valid), 0);
      chk({tag, "_res_ch"}, int'(res_ch), 0);
      chk({tag, "_res_phase"}, int'(res_phase), 0);
      chk({tag, "_res_timeout"}, int'(res_timeout), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int g;
      rst_n      = 1'b0;
      enable     = 1'b0;
      ch_mask    = '0;
      avg_log2   = 2'd0;
      core_done  = 1'b0;
      core_phase = '0;
      m_cur      = NUM_CH - 1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("reset");

      // Enabled with an empty mask: scheduler must stay idle
      enable = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_core_rst_n", int'(core_rst_n), 0);

      ch_mask = 3'b001;
      sbuf[0] = 90;
      run_job(0, 1'b1, 50);
      run_job(0, 1'b0, -1);

      avg_log2 = 2'd2;
      sbuf[0] = 358; sbuf[1] = 2; sbuf[2] = 0; sbuf[3] = 4;
      run_job(2, 1'b1, -1);
      sbuf[0] = 10; sbuf[1] = 20; sbuf[2] = 30; sbuf[3] = 40;
      run_job(2, 1'b1, -1);

      ch_mask  = 3'b101;
      avg_log2 = 2'd0;
      for (int j = 0; j < 3; j++) run_job(0, 1'b0, -1);
      mid_en   = 1'b1;
      mid_mask = 3'b010;
      run_job(0, 1'b0, -1);
      mid_en   = 1'b0;
      run_job(0, 1'b0, -1);

      run_timeout();
      run_job(0, 1'b0, TO_CYC - 1);

      // Drop enable part-way through a 4-sample average
      ch_mask  = 3'b001;
      avg_log2 = 2'd2;
      m_cur    = model_next(ch_mask);
      for (int i = 0; i < 2; i++) begin
         await_wait(w0);
         chk("drop_sel_b", int'(sel_b), m_cur);
         repeat (5) @(negedge clk);
         core_phase = 9'd200;
         core_done  = 1'b1;
         @(negedge clk);
         core_done  = 1'b0;
      end
      await_wait(w0);
      repeat (3) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("drop_busy", int'(busy), 0);
      chk("drop_core_rst_n", int'(core_rst_n), 0);
      repeat (10) @(negedge clk);
      enable = 1'b1;
      sbuf[0] = 350; sbuf[1] = 355; sbuf[2] = 5; sbuf[3] = 10;
      run_job(2, 1'b1, -1);

      // Synchronous reset while the core is being restarted
      ch_mask  = 3'b011;
      avg_log2 = 2'd0;
      g = 0;
      while (core_rst_n && g < 100) begin @(negedge clk); g++; end
      if (g >= 100) fail_bound("reach_reset_state");
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      rst_n = 1'b1;
      m_cur = NUM_CH - 1;
      run_job(0, 1'b0, -1);

      for (int j = 0; j < 6; j++) begin
         ch_mask  = 3'($urandom_range(1, 7));
         avg_log2 = 2'($urandom_range(0, 3));
         run_job(int'(avg_log2), 1'b0, -1);
      end

      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      chk("pending_results", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
